carregador_hd_mi: RTL and testbench

Program loader that copies a block of words from the simulated HD into the instruction memory. It is the write side of the instruction path: the CPU only reads instruction memory, and this block fills it. `controla_so` starts it with `bloq_cpu` asserted while the BIOS hands control to a loaded program. It walks HD sectors sequentially, crossing track boundaries as needed, and reports completion or a range error.

---
 rtl/pkg_so.sv | 7 +
 rtl/gerador_endereco_hd.sv | 30 +++
 rtl/carregador_hd_mi.sv | 84 ++++++++
 tb/tb_carregador_hd_mi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_so.sv
// pkg_so: shared OS-level loader states and HD/MI constants
package pkg_so;
    typedef enum logic [1:0] {OCIOSO, ENDERECA, ESCREVE, FIM} estado_carregador_t;
    localparam int TAM_MI = 64;
    localparam int NUM_SETORES = 64;
    localparam int LAT_HD_SO = 1;
endpackage

// File: rtl/gerador_endereco_hd.sv
// gerador_endereco_hd: loadable track/sector counter with sector-to-track carry
module gerador_endereco_hd
    import pkg_so::*;
#(
    parameter int LARG_SETOR = 6,
    parameter int LARG_TRILHA = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   carrega,
    input  logic                   incrementa,
    input  logic [LARG_TRILHA-1:0] trilha_ini,
    input  logic [LARG_SETOR-1:0]  setor_ini,
    output logic [LARG_TRILHA-1:0] trilha,
    output logic [LARG_SETOR-1:0]  setor
);
    logic ultimo;
    assign ultimo = setor == LARG_SETOR'(NUM_SETORES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            trilha <= '0;
            setor  <= '0;
        end else if (carrega) begin
            trilha <= trilha_ini;
            setor  <= setor_ini;
        end else if (incrementa) begin
            setor  <= ultimo ? '0 : setor + 1'b1;
            trilha <= ultimo ? trilha + 1'b1 : trilha;
        end
endmodule

// File: rtl/carregador_hd_mi.sv
// carregador_hd_mi: copies a block of HD words into instruction memory
module carregador_hd_mi
    import pkg_so::*;
#(
    parameter int LARG_DADO = 32,
    parameter int LARG_END_MI = 6,
    parameter int LARG_SETOR = 6,
    parameter int LARG_TRILHA = 4,
    parameter int LAT_HD = LAT_HD_SO
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inicia,
    input  logic [LARG_TRILHA-1:0] trilha_orig,
    input  logic [LARG_SETOR-1:0]  setor_orig,
    input  logic [LARG_END_MI-1:0] end_dest,
    input  logic [LARG_END_MI:0]   num_palavras,
    output logic [LARG_TRILHA-1:0] hd_trilha,
    output logic [LARG_SETOR-1:0]  hd_setor,
    input  logic [LARG_DADO-1:0]   hd_dado,
    output logic                   mi_hab_esc,
    output logic [LARG_END_MI-1:0] mi_ender,
    output logic [LARG_DADO-1:0]   mi_dado,
    output logic                   ocupado,
    output logic                   concluido,
    output logic                   erro
);
    localparam int LARG_LAT = LAT_HD > 1 ? $clog2(LAT_HD) : 1;
    localparam int LARG_CONT = LARG_END_MI + 1;
    estado_carregador_t estado;
    logic [LARG_LAT-1:0] lat;
    logic [LARG_CONT-1:0] restante;
    logic direto, rejeita, vazio, aceita, lat_fim;
    assign rejeita = num_palavras > LARG_CONT'(TAM_MI)
                  || ({1'b0, end_dest} + num_palavras) > LARG_CONT'(TAM_MI);
    assign vazio = num_palavras == '0;
    assign aceita = estado == OCIOSO && inicia;
    assign lat_fim = lat == LARG_LAT'(LAT_HD - 1);
    assign ocupado = estado == ENDERECA || estado == ESCREVE;
    assign mi_hab_esc = estado == ESCREVE;
    assign mi_dado = hd_dado;
    gerador_endereco_hd #(.LARG_SETOR(LARG_SETOR), .LARG_TRILHA(LARG_TRILHA)) u_gerador (
        .clk(clk),
        .reset(reset),
        .carrega(aceita),
        .incrementa(estado == ESCREVE),
        .trilha_ini(trilha_orig),
        .setor_ini(setor_orig),
        .trilha(hd_trilha),
        .setor(hd_setor)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            estado    <= OCIOSO;
            lat       <= '0;
            restante  <= '0;
            mi_ender  <= '0;
            erro      <= 1'b0;
            concluido <= 1'b0;
            direto    <= 1'b0;
        end else begin
            concluido <= (estado == ESCREVE && restante == LARG_CONT'(1)) || (estado == FIM && direto);
            case (estado)
                OCIOSO: if (inicia) begin
                    mi_ender <= end_dest;
                    restante <= num_palavras;
                    lat      <= '0;
                    erro     <= rejeita;
                    direto   <= rejeita || vazio;
                    estado   <= (rejeita || vazio) ? FIM : ENDERECA;
                end
                ENDERECA: begin
                    lat    <= lat_fim ? '0 : lat + 1'b1;
                    estado <= lat_fim ? ESCREVE : ENDERECA;
                end
                ESCREVE: begin
                    mi_ender <= mi_ender + 1'b1;
                    restante <= restante - 1'b1;
                    estado   <= restante == LARG_CONT'(1) ? FIM : ENDERECA;
                end
                FIM: estado <= OCIOSO;
            endcase
        end
endmodule

// File: tb/tb_carregador_hd_mi.sv
// tb_carregador_hd_mi: table-driven scoreboard bench for the HD-to-MI loader
module tb_carregador_hd_mi;
    typedef struct { logic [5:0] ender; logic [31:0] dado; int ciclo; } esc_t;
    typedef struct { logic [3:0] t; logic [5:0] s; logic [5:0] d; logic [6:0] n; logic erro; } vet_t;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    int checks = 0, failures = 0, n_esc_a = 0;
    esc_t esc_a[$], esc_b[$];
    int conc_a[$], conc_b[$];

    logic inicia_a, inicia_b;
    logic [3:0] trilha_a, trilha_b, hd_trilha_a, hd_trilha_b;
    logic [5:0] setor_a, setor_b, hd_setor_a, hd_setor_b;
    logic [5:0] dest_a, dest_b, mi_ender_a, mi_ender_b;
    logic [6:0] num_a, num_b;
    logic [31:0] hd_a, hd_b1, hd_b2, hd_b3, mi_dado_a, mi_dado_b;
    logic mi_hab_esc_a, mi_hab_esc_b, ocupado_a, ocupado_b, concluido_a, concluido_b, erro_a, erro_b;

    carregador_hd_mi #(.LAT_HD(1)) dut_a (
        .clk(clk), .reset(reset), .inicia(inicia_a), .trilha_orig(trilha_a), .setor_orig(setor_a),
        .end_dest(dest_a), .num_palavras(num_a), .hd_trilha(hd_trilha_a), .hd_setor(hd_setor_a),
        .hd_dado(hd_a), .mi_hab_esc(mi_hab_esc_a), .mi_ender(mi_ender_a), .mi_dado(mi_dado_a),
        .ocupado(ocupado_a), .concluido(concluido_a), .erro(erro_a)
    );
    carregador_hd_mi #(.LAT_HD(3)) dut_b (
        .clk(clk), .reset(reset), .inicia(inicia_b), .trilha_orig(trilha_b), .setor_orig(setor_b),
        .end_dest(dest_b), .num_palavras(num_b), .hd_trilha(hd_trilha_b), .hd_setor(hd_setor_b),
        .hd_dado(hd_b3), .mi_hab_esc(mi_hab_esc_b), .mi_ender(mi_ender_b), .mi_dado(mi_dado_b),
        .ocupado(ocupado_b), .concluido(concluido_b), .erro(erro_b)
    );

    function automatic logic [31:0] conteudo(input logic [3:0] t, input logic [5:0] s);
        return {16'hC0DE, 6'd0, t, s};
    endfunction

    always @(posedge clk) begin
        hd_a  <= conteudo(hd_trilha_a, hd_setor_a);
        hd_b1 <= conteudo(hd_trilha_b, hd_setor_b);
        hd_b2 <= hd_b1;
        hd_b3 <= hd_b2;
    end

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] exigido);
        checks++;
        if (atual !== exigido) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, exigido, ciclo);
        end
    endtask

    always @(negedge clk) begin : mon_a
        esc_t e;
        if (mi_hab_esc_a) begin
            n_esc_a++;
            verifica("fila_esc_a", esc_a.size() > 0, 1'b1);
            if (esc_a.size() > 0) begin
                e = esc_a.pop_front();
                verifica("ender_a", mi_ender_a, e.ender);
                verifica("dado_a", mi_dado_a, e.dado);
                verifica("ciclo_esc_a", ciclo, e.ciclo);
            end
        end
        if (concluido_a) begin
            verifica("fila_conc_a", conc_a.size() > 0, 1'b1);
            if (conc_a.size() > 0) verifica("ciclo_conc_a", ciclo, conc_a.pop_front());
        end
    end

    always @(negedge clk) begin : mon_b
        esc_t e;
        if (mi_hab_esc_b) begin
            verifica("fila_esc_b", esc_b.size() > 0, 1'b1);
            if (esc_b.size() > 0) begin
                e = esc_b.pop_front();
                verifica("ender_b", mi_ender_b, e.ender);
                verifica("dado_b", mi_dado_b, e.dado);
                verifica("ciclo_esc_b", ciclo, e.ciclo);
            end
        end
        if (concluido_b) begin
            verifica("fila_conc_b", conc_b.size() > 0, 1'b1);
            if (conc_b.size() > 0) verifica("ciclo_conc_b", ciclo, conc_b.pop_front());
        end
    end

    task automatic agenda(input bit b, input int lat, input int k, input logic [3:0] t,
                          input logic [5:0] s, input logic [5:0] d, input int n, input bit rej);
        if (rej || n == 0) begin
            if (b) conc_b.push_back(k + 1); else conc_a.push_back(k + 1);
        end else begin
            for (int j = 0; j < n; j++) begin
                esc_t e;
                e.ender = d + j[5:0];
                e.dado = conteudo(t, s);
                e.ciclo = k + lat + j * (lat + 1);
                if (b) esc_b.push_back(e); else esc_a.push_back(e);
                if (s == 6'd63) begin
                    s = 6'd0;
                    t = t + 4'd1;
                end else s = s + 6'd1;
            end
            if (b) conc_b.push_back(k + n * (lat + 1)); else conc_a.push_back(k + n * (lat + 1));
        end
    endtask

    task automatic inicia_tx(input bit b, input logic [3:0] t, input logic [5:0] s,
                             input logic [5:0] d, input logic [6:0] n, output int k);
        @(negedge clk);
        if (b) begin
            trilha_b = t; setor_b = s; dest_b = d; num_b = n; inicia_b = 1'b1;
        end else begin
            trilha_a = t; setor_a = s; dest_a = d; num_a = n; inicia_a = 1'b1;
        end
        @(posedge clk);
        #1 k = ciclo;
        @(negedge clk);
        inicia_a = 1'b0;
        inicia_b = 1'b0;
    endtask

    task automatic espera(input bit b, input int limite);
        for (int c = 0; c < limite && (b ? esc_b.size() + conc_b.size() : esc_a.size() + conc_a.size()) > 0; c++)
            @(negedge clk);
        verifica(b ? "pendente_b" : "pendente_a", b ? esc_b.size() + conc_b.size() : esc_a.size() + conc_a.size(), 0);
        @(negedge clk);
    endtask

    vet_t tab[8];

    initial begin
        int k, base;
        inicia_a = 1'b0; trilha_a = '0; setor_a = '0; dest_a = '0; num_a = '0;
        inicia_b = 1'b0; trilha_b = '0; setor_b = '0; dest_b = '0; num_b = '0;
        tab[0] = '{4'd2,  6'd5,  6'd0,  7'd4,  1'b0};
        tab[1] = '{4'd7,  6'd62, 6'd10, 7'd3,  1'b0};
        tab[2] = '{4'd0,  6'd0,  6'd60, 7'd5,  1'b1};
        tab[3] = '{4'd1,  6'd0,  6'd20, 7'd2,  1'b0};
        tab[4] = '{4'd3,  6'd3,  6'd5,  7'd0,  1'b0};
        tab[5] = '{4'd4,  6'd0,  6'd0,  7'd65, 1'b1};
        tab[6] = '{4'd15, 6'd63, 6'd60, 7'd4,  1'b0};
        tab[7] = '{4'd9,  6'd0,  6'd0,  7'd64, 1'b0};
        #1;
        verifica("rst_ocupado", ocupado_a, 1'b0);
        verifica("rst_hab_esc", mi_hab_esc_a, 1'b0);
        verifica("rst_concluido", concluido_a, 1'b0);
        verifica("rst_erro", erro_a, 1'b0);
        verifica("rst_endereco", {hd_trilha_a, hd_setor_a, mi_ender_a}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            inicia_tx(1'b0, tab[i].t, tab[i].s, tab[i].d, tab[i].n, k);
            agenda(1'b0, 1, k, tab[i].t, tab[i].s, tab[i].d, int'(tab[i].n), tab[i].erro);
            espera(1'b0, 200);
            verifica($sformatf("erro_vet%0d", i), erro_a, tab[i].erro);
            verifica($sformatf("ocioso_vet%0d", i), ocupado_a, 1'b0);
        end

        @(negedge clk);
        trilha_a = 4'd0; setor_a = 6'd0; dest_a = 6'd0; num_a = 7'd0; inicia_a = 1'b1;
        @(posedge clk);
        #1 k = ciclo;
        conc_a.push_back(k + 1);
        conc_a.push_back(k + 3);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        inicia_a = 1'b0;
        espera(1'b0, 20);

        base = n_esc_a;
        inicia_tx(1'b0, 4'd3, 6'd0, 6'd0, 7'd10, k);
        agenda(1'b0, 1, k, 4'd3, 6'd0, 6'd0, 10, 1'b0);
        for (int c = 0; c < 50 && n_esc_a < base + 3; c++) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        verifica("abort_ocupado", ocupado_a, 1'b0);
        verifica("abort_hab_esc", mi_hab_esc_a, 1'b0);
        verifica("abort_concluido", concluido_a, 1'b0);
        verifica("abort_endereco", {hd_trilha_a, hd_setor_a, mi_ender_a}, 16'd0);
        esc_a.delete();
        conc_a.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        verifica("escritas_ate_abort", n_esc_a - base, 3);

        inicia_tx(1'b1, 4'd2, 6'd5, 6'd40, 7'd2, k);
        agenda(1'b1, 3, k, 4'd2, 6'd5, 6'd40, 2, 1'b0);
        trilha_b = 4'd0; setor_b = 6'd0; dest_b = 6'd0; num_b = 7'd5; inicia_b = 1'b1;
        verifica("ocupado_b", ocupado_b, 1'b1);
        @(negedge clk);
        inicia_b = 1'b0;
        espera(1'b1, 40);
        verifica("erro_b", erro_b, 1'b0);
        repeat (10) @(negedge clk);
        verifica("fim_filas", esc_a.size() + esc_b.size() + conc_a.size() + conc_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
